seg_display_driver: RTL and testbench
=====================================

// Module: seg_display_driver
// PURPOSE
//  Downstream output stage of the CPU. Latches a 16-bit value from the core and shows it as
//  4 hex digits on a time-multiplexed common-anode 7-segment display via SEG/SEG_SEL.
//  Display updates are frame-atomic: no torn values. The dp of digit 0 shows the halt state.
// PARAMETERS
//  DIV_WIDTH  16  scan prescaler width; per-digit period = 2**DIV_WIDTH CLK cycles (legal >= 2)
//  LZB        0   1: blank leading zero digits 3..1; digit 0 is always shown
// PORTS
//  CLK       in   1   system clock; all state changes on posedge
//  rst       in   1   synchronous, active-high reset
//  value     in   16  value to display (e.g. a register-file word)
//  value_we  in   1   sample value into the pending register this cycle
//  do_halt   in   1   CPU halted; lights the dp of digit 0
//  SEG       out  8   active-low segments {dp,g,f,e,d,c,b,a}
//  SEG_SEL   out  4   active-low digit enable; bit0 = rightmost digit (value[3:0])
// BEHAVIOUR
//  - Registers: cnt[DIV_WIDTH], state {BLANK,SHOW}, dig[2], pending[16], shadow[16], pend_v.
//  - SEG/SEG_SEL are decoded from registers only. No combinational path from any input.
//  - Reset: cnt=0, state=BLANK, dig=0, pending=0, shadow=0, pend_v=0, SEG=8'hFF, SEG_SEL=4'hF.
//  - Reset has priority over every other event, including mid-scan and mid-update.
//  - cnt is free-running and wraps at 2**DIV_WIDTH-1. tick = (cnt == 2**DIV_WIDTH-1).
//  - FSM transitions:
//      BLANK -> SHOW on the next cycle, unconditionally.
//      SHOW  -> BLANK on tick; dig <= dig+1 in the same edge (wraps 3 -> 0).
//    Each digit is therefore 1 blank cycle + (2**DIV_WIDTH - 1) show cycles.
//  - BLANK state output: SEG=8'hFF, SEG_SEL=4'hF (ghosting guard).
//  - SHOW state output: SEG_SEL = ~(4'b0001 << dig).
//    SEG[6:0] = font(shadow[4*dig +: 4]).
//    SEG[7]   = ~(do_halt_q && dig==0), where do_halt_q is do_halt registered once.
//  - Font table (active-low gfedcba):
//      0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
//  - LZB=1: digit k (k=3..1) outputs SEG[6:0]=7'h7F when shadow[15:4*k] == 0.
//    SEG_SEL still asserts for a blanked digit. The dp rule is unchanged.
//  - Update path:
//    * value_we=1: pending <= value, pend_v <= 1.
//    * Frame boundary = tick while dig==3.
//    * At a frame boundary with pend_v=1: shadow <= pending, pend_v <= 0.
//    * value_we at the frame boundary: value goes straight to shadow, pend_v <= 0.
//    * Back-to-back value_we: last write wins.
//    * shadow never changes except at a frame boundary (or reset).
// TESTING (bench uses DIV_WIDTH=2: 1 blank + 3 show cycles per digit, 16-cycle frame)
//  1 rst=1 for 2 cycles -> SEG=FF, SEG_SEL=F.
//    After release: 1 blank cycle, then SEG_SEL=1110, SEG=C0 for 3 cycles.
//  2 Free scan, value 0 -> SEG_SEL cycles 1110,1101,1011,0111, each preceded by 1111;
//    pattern repeats every 16 cycles.
//  3 value_we with value=16'h0007 mid-frame -> digits unchanged until dig wraps 3->0.
//    Then digit0 SEG=F8, digits 1-3 SEG=C0.
//    Same run with LZB=1 -> digits 1-3 SEG=FF, digit0 SEG=F8.
//  4 value_we 16'hA5C3 on the boundary cycle, then 16'h1234 one cycle later.
//    Next frame shows 3,C,5,A = 30,46,12,08.
//    The frame after that shows 4,3,2,1.
//  5 do_halt=1 -> from the next digit-0 slot SEG=78 for value 7 (dp lit).
//    Digits 1-3 keep SEG[7]=1.
//  6 rst pulse while dig=2 and pend_v=1 -> SEG=FF, SEG_SEL=F, shadow=0.
//    Pending value is discarded; scan restarts at digit 0.

Source files
------------

// File: rtl/seg_display_driver.sv
// Four-digit hex driver for a multiplexed common-anode 7-segment display.
// New values are staged in a pending register and only reach the display at frame boundaries.
module seg_display_driver #(
    parameter int DIV_WIDTH = 16,
    parameter bit LZB       = 1'b0
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        value_we,
    input  logic        do_halt,
    output logic [7:0]  SEG,
    output logic [3:0]  SEG_SEL
);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    state_t               state_q, state_d;
    logic [1:0]           dig_q, dig_d;
    logic [15:0]          pending_q, pending_d;
    logic [15:0]          shadow_q, shadow_d;
    logic                 pend_v_q, pend_v_d;
    logic                 do_halt_q, do_halt_d;

    logic                 tick;
    logic                 frame_end;
    logic [3:0]           nibble;
    logic                 lead_zero;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0:    font = 7'h40;
            4'h1:    font = 7'h79;
            4'h2:    font = 7'h24;
            4'h3:    font = 7'h30;
            4'h4:    font = 7'h19;
            4'h5:    font = 7'h12;
            4'h6:    font = 7'h02;
            4'h7:    font = 7'h78;
            4'h8:    font = 7'h00;
            4'h9:    font = 7'h10;
            4'hA:    font = 7'h08;
            4'hB:    font = 7'h03;
            4'hC:    font = 7'h46;
            4'hD:    font = 7'h21;
            4'hE:    font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt_q     <= '0;
            state_q   <= BLANK;
            dig_q     <= 2'd0;
            pending_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            pend_v_q  <= 1'b0;
            do_halt_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            dig_q     <= dig_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            pend_v_q  <= pend_v_d;
            do_halt_q <= do_halt_d;
        end
    end

    assign tick      = (cnt_q == {DIV_WIDTH{1'b1}});
    assign frame_end = tick && (dig_q == 2'd3);

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        state_d   = state_q;
        dig_d     = dig_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        pend_v_d  = pend_v_q;
        do_halt_d = do_halt;

        case (state_q)
            BLANK: state_d = SHOW;
            SHOW: begin
                if (tick) begin
                    state_d = BLANK;
                    dig_d   = dig_q + 2'd1;
                end
            end
            default: state_d = BLANK;
        endcase

        // A write landing exactly on the boundary bypasses pending so it is not delayed a frame.
        if (frame_end) begin
            if (value_we) begin
                shadow_d  = value;
                pending_d = value;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
            end
            pend_v_d = 1'b0;
        end else if (value_we) begin
            pending_d = value;
            pend_v_d  = 1'b1;
        end
    end

    always_comb begin
        nibble    = shadow_q[3:0];
        lead_zero = 1'b0;
        case (dig_q)
            2'd0: nibble = shadow_q[3:0];
            2'd1: begin
                nibble    = shadow_q[7:4];
                lead_zero = (shadow_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble    = shadow_q[11:8];
                lead_zero = (shadow_q[15:8] == 8'h00);
            end
            default: begin
                nibble    = shadow_q[15:12];
                lead_zero = (shadow_q[15:12] == 4'h0);
            end
        endcase
    end

    // Outputs come from registers only; BLANK turns everything off between digits.
    always_comb begin
        SEG     = 8'hFF;
        SEG_SEL = 4'hF;
        if (state_q == SHOW) begin
            SEG_SEL  = ~(4'b0001 << dig_q);
            SEG[6:0] = (LZB && lead_zero) ? 7'h7F : font(nibble);
            SEG[7]   = ~(do_halt_q && (dig_q == 2'd0));
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a 16-cycle frame; runs a plain and a
// leading-zero-blanking instance side by side on the same stimulus.
module tb_seg_display_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        value_we;
    logic        do_halt;
    logic [7:0]  seg;
    logic [3:0]  seg_sel;
    logic [7:0]  seg_lzb;
    logic [3:0]  seg_sel_lzb;

    int tests_run    = 0;
    int tests_failed = 0;

    seg_display_driver #(.DIV_WIDTH(2), .LZB(1'b0)) dut (
        .CLK     (clk),
        .rst     (rst),
        .value   (value),
        .value_we(value_we),
        .do_halt (do_halt),
        .SEG     (seg),
        .SEG_SEL (seg_sel)
    );

    seg_display_driver #(.DIV_WIDTH(2), .LZB(1'b1)) dut_lzb (
        .CLK     (clk),
        .rst     (rst),
        .value   (value),
        .value_we(value_we),
        .do_halt (do_halt),
        .SEG     (seg_lzb),
        .SEG_SEL (seg_sel_lzb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [15:0] val, input logic halt);
        value_we = we;
        value    = val;
        do_halt  = halt;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Checks frame positions 0..last_p; codes are {dig3,dig2,dig1,dig0} full SEG bytes.
    // Inputs chosen in position p are sampled at the edge that ends p.
    task automatic checkFrame(input string tag, input logic [31:0] codes, input logic [31:0] lzb_codes,
                              input int last_p, input int we_p, input logic [15:0] we_v,
                              input int halt_p, input logic halt_v);
        logic [7:0] exp_seg;
        logic [7:0] exp_lzb;
        logic [3:0] exp_sel;
        logic       halt_now;
        for (int p = 0; p <= last_p; p++) begin
            if (p % 4 == 0) begin
                exp_seg = 8'hFF;
                exp_lzb = 8'hFF;
                exp_sel = 4'hF;
            end else begin
                exp_seg = codes[8*(p/4) +: 8];
                exp_lzb = lzb_codes[8*(p/4) +: 8];
                exp_sel = ~(4'b0001 << (p/4));
            end
            checkOutput($sformatf("%s p%0d seg", tag, p), seg, exp_seg);
            checkOutput($sformatf("%s p%0d sel", tag, p), {4'h0, seg_sel}, {4'h0, exp_sel});
            checkOutput($sformatf("%s p%0d lzb_seg", tag, p), seg_lzb, exp_lzb);
            checkOutput($sformatf("%s p%0d lzb_sel", tag, p), {4'h0, seg_sel_lzb}, {4'h0, exp_sel});
            halt_now = (p == halt_p) ? halt_v : do_halt;
            applyStimulus(p == we_p, (p == we_p) ? we_v : 16'h0000, halt_now);
            stepCycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0);

        // Reset state
        stepCycle();
        stepCycle();
        checkOutput("reset seg", seg, 8'hFF);
        checkOutput("reset sel", {4'h0, seg_sel}, 8'h0F);
        checkOutput("reset lzb_seg", seg_lzb, 8'hFF);
        rst = 1'b0;

        // Free scan of zero, then a mid-frame write that must wait for the boundary
        checkFrame("f0_zero", 32'hC0C0C0C0, 32'hFFFFFFC0, 15, -1, 16'h0000, -1, 1'b0);
        checkFrame("f1_zero", 32'hC0C0C0C0, 32'hFFFFFFC0, 15, -1, 16'h0000, -1, 1'b0);
        checkFrame("f2_midwr", 32'hC0C0C0C0, 32'hFFFFFFC0, 15, 6, 16'h0007, -1, 1'b0);

        // 0007 shown; boundary write of A5C3, then 1234 one cycle later
        checkFrame("f3_0007", 32'hC0C0C0F8, 32'hFFFFFFF8, 15, 15, 16'hA5C3, -1, 1'b0);
        checkFrame("f4_A5C3", 32'h8892C6B0, 32'h8892C6B0, 15, 0, 16'h1234, -1, 1'b0);
        checkFrame("f5_1234", 32'hF9A4B099, 32'hF9A4B099, 15, 7, 16'h0007, -1, 1'b0);

        // Halt raised after the digit-0 slot: dp lights only from the next frame
        checkFrame("f6_halt_set", 32'hC0C0C0F8, 32'hFFFFFFF8, 15, -1, 16'h0000, 5, 1'b1);
        checkFrame("f7_halt_dp", 32'hC0C0C078, 32'hFFFFFF78, 15, -1, 16'h0000, -1, 1'b1);

        // Reset while digit 2 is showing and a write is pending
        checkFrame("f8_pre_rst", 32'hC0C0C0F8, 32'hFFFFFFF8, 8, 2, 16'hBEEF, 0, 1'b0);
        checkOutput("f8 p9 dig2 sel", {4'h0, seg_sel}, 8'h0B);
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst seg", seg, 8'hFF);
        checkOutput("midrst sel", {4'h0, seg_sel}, 8'h0F);
        rst = 1'b0;
        checkFrame("f9_after_rst", 32'hC0C0C0C0, 32'hFFFFFFC0, 15, -1, 16'h0000, -1, 1'b0);
        checkFrame("f10_discard", 32'hC0C0C0C0, 32'hFFFFFFC0, 15, -1, 16'h0000, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
